// File: rtl/audio_sample_fifo.sv
// Stereo sample buffer between the packet decoder and the I2S sender.
// Handles stream start, priming, host refill requests, underrun and idle timeout.
module audio_sample_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int PRIME_LEVEL = 8,
    parameter int REQ_LEVEL   = 8,
    parameter int BURST       = 8,
    parameter int TIMEOUT     = 50000,
    parameter int TW          = 16
) (
    input  logic                  mon_clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    input  logic                  audio_starts,
    input  logic                  pop,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    output logic                  audio_req,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  playing,
    output logic                  underrun,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int CW    = $clog2(BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        PLAY
    } state_t;

    state_t                state, state_next;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_addr;
    logic [TW-1:0]         tmo_cnt;
    logic                  req_pending;
    logic [CW-1:0]         req_cnt;

    logic active, is_empty, is_full, pop_data, push_acc, timed_out, req_fire;

    always_comb begin
        active    = (state != IDLE);
        is_empty  = (level == '0);
        is_full   = (level == LW'(DEPTH));
        pop_data  = pop && !audio_starts && (state == PLAY) && !is_empty;
        // A pop on a full buffer frees the slot the simultaneous push lands in.
        push_acc  = in_valid && (audio_starts || (active && (!is_full || pop_data)));
        timed_out = (state == PLAY) && is_empty && !in_valid && (tmo_cnt == TW'(TIMEOUT));
        wr_addr   = audio_starts ? '0 : wr_ptr;

        state_next = state;
        if (audio_starts) begin
            state_next = PRIME;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                PRIME:   if (level >= LW'(PRIME_LEVEL)) state_next = PLAY;
                PLAY:    if (timed_out) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        req_fire = active && !audio_starts && !timed_out && !req_pending &&
                   (level <= LW'(REQ_LEVEL));
    end

    assign playing = (state == PLAY);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            state <= state_next;
            if (audio_starts) begin
                wr_ptr <= DEPTH_LOG2'(push_acc);
                rd_ptr <= '0;
                level  <= LW'(push_acc);
            end else begin
                if (push_acc) wr_ptr <= wr_ptr + 1'b1;
                if (pop_data) rd_ptr <= rd_ptr + 1'b1;
                level <= level + LW'(push_acc) - LW'(pop_data);
            end
        end
    end

    // NOTE: the sample array has no reset; its contents are don't-care until written.
    always_ff @(posedge mon_clk) begin
        if (push_acc) mem[wr_addr] <= in_data;
    end

    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
            audio_req <= 1'b0;
        end else begin
            out_valid <= pop;
            underrun  <= pop && !audio_starts && (state == PLAY) && is_empty;
            overflow  <= in_valid && active && !audio_starts && is_full && !pop_data;
            audio_req <= req_fire;
            if (pop) out_data <= pop_data ? mem[rd_ptr] : '0;
        end
    end

    // The request stays pending until BURST samples have actually been stored.
    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pending <= 1'b0;
            req_cnt     <= '0;
        end else if (audio_starts || timed_out) begin
            req_pending <= 1'b0;
            req_cnt     <= '0;
        end else if (req_fire) begin
            req_pending <= 1'b1;
            req_cnt     <= '0;
        end else if (req_pending && push_acc) begin
            if (req_cnt == CW'(BURST - 1)) req_pending <= 1'b0;
            req_cnt <= req_cnt + 1'b1;
        end
    end

    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (audio_starts || (state != PLAY) || !is_empty || in_valid) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TW'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo: directed test-plan steps followed by
// randomized traffic, all compared cycle by cycle against a queue-based reference model.
module tb_audio_sample_fifo;

    localparam int DEPTH       = 16;
    localparam int PRIME_LEVEL = 8;
    localparam int REQ_LEVEL   = 8;
    localparam int BURST       = 8;
    localparam int TIMEOUT     = 50000;
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_PLAY  = 2;

    logic        mon_clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        audio_starts;
    logic        pop;
    logic [31:0] out_data;
    logic        out_valid;
    logic        audio_req;
    logic [4:0]  level;
    logic        playing;
    logic        underrun;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    // Reference model state: sample queue, stream mode and request bookkeeping.
    logic [31:0] q[$];
    int          mode;
    bit          pend;
    int          rcnt;
    int          idle;
    logic [31:0] e_data;
    bit          e_valid, e_req, e_under, e_over;

    audio_sample_fifo #(
        .DEPTH_LOG2 (4),
        .PRIME_LEVEL(PRIME_LEVEL),
        .REQ_LEVEL  (REQ_LEVEL),
        .BURST      (BURST),
        .TIMEOUT    (TIMEOUT),
        .TW         (16)
    ) dut (
        .mon_clk     (mon_clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .audio_starts(audio_starts),
        .pop         (pop),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .audio_req   (audio_req),
        .level       (level),
        .playing     (playing),
        .underrun    (underrun),
        .overflow    (overflow)
    );

    always #5 mon_clk = ~mon_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode = M_IDLE; pend = 0; rcnt = 0; idle = 0;
        e_data = '0; e_valid = 0; e_req = 0; e_under = 0; e_over = 0;
    endtask

    task automatic model_step(input bit iv, input logic [31:0] d, input bit st, input bit pp);
        int size0;
        bit acc;
        bit leave;
        size0   = q.size();
        e_valid = pp; e_under = 0; e_over = 0; e_req = 0;
        if (st) begin
            if (pp) e_data = '0;
            q.delete();
            if (iv) q.push_back(d);
            pend = 0; rcnt = 0; idle = 0; mode = M_PRIME;
        end else begin
            leave = (mode == M_PLAY) && (size0 == 0) && !iv && (idle == TIMEOUT);
            if (pp) begin
                if (mode == M_PLAY && size0 > 0) begin
                    e_data = q.pop_front();
                end else begin
                    e_data  = '0;
                    e_under = (mode == M_PLAY);
                end
            end
            acc = 0;
            if (iv && mode != M_IDLE) begin
                if (q.size() < DEPTH) begin
                    q.push_back(d);
                    acc = 1;
                end else begin
                    e_over = 1;
                end
            end
            if (!pend && mode != M_IDLE && !leave && size0 <= REQ_LEVEL) begin
                e_req = 1; pend = 1; rcnt = 0;
            end else if (pend && acc) begin
                rcnt++;
                if (rcnt == BURST) pend = 0;
            end
            if (mode == M_PLAY && size0 == 0 && !iv) idle = (idle < TIMEOUT) ? idle + 1 : TIMEOUT;
            else idle = 0;
            if (leave) begin
                mode = M_IDLE; pend = 0;
            end else if (mode == M_PRIME && size0 >= PRIME_LEVEL) begin
                mode = M_PLAY;
            end
        end
    endtask

    task automatic compare_all();
        check("level",     32'(level),     32'(q.size()));
        check("playing",   32'(playing),   32'(mode == M_PLAY));
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("out_data",  out_data,       e_data);
        check("audio_req", 32'(audio_req), 32'(e_req));
        check("underrun",  32'(underrun),  32'(e_under));
        check("overflow",  32'(overflow),  32'(e_over));
    endtask

    // Called at a falling edge; drives one cycle of inputs and checks the result.
    task automatic step(input bit iv, input logic [31:0] d, input bit st, input bit pp);
        in_valid = iv; in_data = d; audio_starts = st; pop = pp;
        @(posedge mon_clk);
        model_step(iv, d, st, pp);
        #1;
        compare_all();
        @(negedge mon_clk);
        in_valid = 1'b0; in_data = '0; audio_starts = 1'b0; pop = 1'b0;
    endtask

    initial begin
        int n;
        int ov_count;
        int push_pct;
        int pop_pct;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; audio_starts = 1'b0; pop = 1'b0;
        model_reset();
        #12;
        compare_all();
        check("reset_level", 32'(level), 32'd0);
        @(negedge mon_clk);
        rst_n = 1'b1;

        // Start a stream and prime it with eight samples.
        step(0, '0, 1, 0);
        check("start_no_req", 32'(audio_req), 32'd0);
        step(0, '0, 0, 0);
        check("start_req", 32'(audio_req), 32'd1);
        for (int k = 1; k <= 8; k++) step(1, 32'h0001_0001 * k, 0, 0);
        check("prime_level8", 32'(level), 32'd8);
        step(0, '0, 0, 0);
        check("play_rise", 32'(playing), 32'd1);

        // Drain in order, then one pop too many.
        for (int k = 1; k <= 8; k++) begin
            step(0, '0, 0, 1);
            check("drain_data", out_data, 32'h0001_0001 * k);
        end
        check("drained_level", 32'(level), 32'd0);
        step(0, '0, 0, 1);
        check("underrun_data", out_data, 32'd0);
        check("underrun_pulse", 32'(underrun), 32'd1);

        // Overfill by one.
        ov_count = 0;
        for (int k = 1; k <= 17; k++) begin
            step(1, 32'hA000_0000 + k, 0, 0);
            if (overflow === 1'b1) ov_count++;
        end
        check("overflow_count", 32'(ov_count), 32'd1);
        check("overflow_last", 32'(overflow), 32'd1);
        check("full_level", 32'(level), 32'd16);

        // Push and pop together while full.
        step(1, 32'hB000_0000, 0, 1);
        check("full_pp_data", out_data, 32'hA000_0001);
        check("full_pp_ovf", 32'(overflow), 32'd0);
        check("full_pp_level", 32'(level), 32'd16);
        for (int k = 0; k < 16; k++) begin
            step(0, '0, 0, 1);
            check("full_drain", out_data, (k < 15) ? 32'hA000_0002 + k : 32'hB000_0000);
        end

        // Idle timeout back to IDLE.
        n = 0;
        while (playing === 1'b1 && n < TIMEOUT + 100) begin
            step(0, '0, 0, 0);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
        check("timeout_playing", 32'(playing), 32'd0);
        for (int k = 0; k < 10; k++) begin
            step(0, '0, 0, 0);
            check("idle_no_req", 32'(audio_req), 32'd0);
        end
        step(0, '0, 0, 1);
        check("idle_pop_data", out_data, 32'd0);
        check("idle_pop_valid", 32'(out_valid), 32'd1);
        check("idle_pop_nounder", 32'(underrun), 32'd0);

        // Restart with a push in the same cycle while partially filled.
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        for (int k = 1; k <= 5; k++) step(1, 32'h0000_0100 + k, 0, 0);
        check("restart_level5", 32'(level), 32'd5);
        step(1, 32'hCAFE_BABE, 1, 0);
        check("restart_level1", 32'(level), 32'd1);
        check("restart_prime", 32'(playing), 32'd0);
        step(0, '0, 0, 1);
        check("restart_req", 32'(audio_req), 32'd1);
        check("prime_pop_data", out_data, 32'd0);
        check("prime_pop_nounder", 32'(underrun), 32'd0);
        check("prime_pop_level", 32'(level), 32'd1);
        for (int k = 1; k <= 7; k++) step(1, 32'h0000_0200 + k, 0, 0);
        step(0, '0, 0, 0);
        check("restart_play", 32'(playing), 32'd1);
        step(0, '0, 0, 1);
        check("restart_first", out_data, 32'hCAFE_BABE);

        // Randomized traffic with varying fill/drain bias and one mid-stream reset.
        push_pct = 50; pop_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                push_pct = 20 + 20 * int'($urandom_range(0, 3));
                pop_pct  = 20 + 20 * int'($urandom_range(0, 3));
            end
            if (i == 2000) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                @(negedge mon_clk);
                rst_n = 1'b1;
            end
            step(int'($urandom_range(0, 99)) < push_pct, $urandom,
                 $urandom_range(0, 149) == 0, int'($urandom_range(0, 99)) < pop_pct);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
